dmem_store_align: RTL and testbench
===================================

# dmem_store_align

Store-side counterpart of the load extraction path: accepts store requests from the memory stage, replicates store data into the correct byte lanes, generates byte strobes, detects misaligned stores, and holds accepted stores in a small FIFO. The FIFO drains into the data-memory write port over a valid/ready handshake. A load-conflict check against pending stores lets the pipeline stall loads that hit a buffered word.

## Interface
- DEPTH, 4, store buffer entries; power of two, at least 2.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- st_valid  in  1  store request valid.
- st_ready  out  1  buffer can take a request; registered, equal to "not full".
- st_addr  in  32  byte address.
- st_wdata  in  32  store value, right-justified (byte in [7:0], half in [15:0]).
- st_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- st_misalign  out  1  one-cycle pulse: the request accepted in the previous cycle was misaligned or illegal.
- st_err_addr  out  32  address of the last misaligned or illegal request; holds until the next error.
- mem_valid  out  1  head entry presented to memory.
- mem_ready  in  1  memory accepts the head entry.
- mem_addr  out  32  word address; [1:0] are always 00.
- mem_wdata  out  32  lane-replicated data.
- mem_wstrb  out  4  byte strobes; bit i covers bits [8i+7:8i].
- ld_addr  in  32  address of the load in the memory stage.
- ld_conflict  out  1  combinational: a valid buffered entry has mem_addr[31:2] equal to ld_addr[31:2].
- buf_empty  out  1  no pending stores; used for fence/drain.

## Operation
- Handshake on input: a request is taken when st_valid and st_ready are both high in the same cycle.
- Alignment rules:
  - byte: data = {4{wdata[7:0]}}, strobe = 0001 shifted left by addr[1:0].
  - half: data = {2{wdata[15:0]}}, strobe = 0011 if addr[1]=0, otherwise 1100. Misaligned if addr[0]=1.
  - word: data = wdata, strobe = 1111. Misaligned if addr[1:0]≠00.
  - size 11: treated as misaligned.
- Misaligned requests:
  - Still consumed by the handshake, but not enqueued.
  - On the next cycle, st_misalign=1 and st_err_addr=st_addr.
- Aligned requests are enqueued as {addr[31:2], data, strobe}.
- FIFO:
  - Circular buffer with write and read pointers of width log2(DEPTH), plus a count.
  - Pointers wrap from DEPTH-1 to 0.
- Output side:
  - mem_valid = (count ≠ 0). mem_addr, mem_wdata and mem_wstrb come from the head entry.
  - Head is popped when mem_valid and mem_ready are both high.
  - Once mem_valid is asserted, mem_addr, mem_wdata and mem_wstrb hold stable until the handshake completes.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Full (count=DEPTH): st_ready=0, including in a cycle where a pop occurs. There is no same-cycle pass-through; st_ready rises the cycle after the pop.
- Stores are never merged or reordered.
- ld_conflict:
  - Compares against all entries in the buffer, including the head while it is being written that cycle.
  - Does not compare against the request being accepted in the same cycle; the pipeline handles that case.

## Timing
- Reset values (cycle after rst_n=0 is sampled): count=0, pointers=0, st_ready=1, mem_valid=0, st_misalign=0, st_err_addr=0, buf_empty=1. mem_addr, mem_wdata and mem_wstrb are 0.
- Inputs are ignored in any cycle where rst_n=0.
- Latency: a request accepted at edge N into an empty buffer gives mem_valid=1 after edge N (one cycle).
- Throughput: one store per cycle in steady state when mem_ready is held high.
- st_misalign is high for exactly one cycle per erroneous request. Back-to-back errors give consecutive pulses.
- Reset mid-operation:
  - All pending entries are discarded and mem_valid drops on the next cycle.
  - This is allowed only when the memory side is reset in the same cycle.
- buf_empty and st_ready are registered and have no combinational path from st_valid or mem_ready.

## Test plan
- Byte store, addr=0x1003, wdata=0x000000AB → after one cycle: mem_valid=1, mem_addr=0x1000, mem_wdata=0xABABABAB, mem_wstrb=1000.
- Half store, addr=0x2002, wdata=0x0000BEEF → mem_wdata=0xBEEFBEEF, mem_wstrb=1100. Half at 0x2001 → st_misalign pulse, st_err_addr=0x2001, nothing enqueued, buf_empty stays 1.
- Hold mem_ready=0 and issue 4 word stores to 0x10, 0x14, 0x18, 0x1C → st_ready=0 after the 4th. Then raise mem_ready for one cycle → head 0x10 written, st_ready=1 on the next cycle. Drain all 4 in FIFO order.
- Simultaneous push and pop at count=2 over 10 cycles → count stays 2, pointers wrap past 3 to 0, output order matches input order.
- With 0x40 buffered: ld_addr=0x43 → ld_conflict=1; ld_addr=0x44 → 0. After the entry drains → 0.
- Reset with 3 entries pending → next cycle: mem_valid=0, buf_empty=1, st_ready=1. A new store to 0x80 appears as the first write.

Source files
------------

// File: rtl/dmem_store_align.sv
// dmem_store_align
//   Store-side alignment and write buffer for the data memory.
//   Each accepted store request has its data replicated into the byte lanes
//   and gets byte strobes. Misaligned or illegal requests are consumed and
//   reported, but they are not buffered. Aligned requests go into a DEPTH-entry
//   circular FIFO. The FIFO drains into the data-memory write port over a
//   valid/ready handshake.
//
// Ports
//   clk, rst_n        clock; synchronous active-low reset
//   st_valid/st_ready store request handshake (st_ready registered, "not full")
//   st_addr/st_wdata  byte address and right-justified store value
//   st_size           00 byte, 01 half, 10 word, 11 illegal
//   st_misalign       one-cycle pulse after a misaligned/illegal request
//   st_err_addr       address of the most recent misaligned/illegal request
//   mem_valid/ready   write-port handshake for the FIFO head
//   mem_addr/wdata/wstrb  head entry: word address, lane data, byte strobes
//   ld_addr           address of the load in the memory stage
//   ld_conflict       a buffered entry targets the same word as ld_addr
//   buf_empty         no pending stores (registered)
module dmem_store_align #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_wdata,
  input  logic [1:0]  st_size,
  output logic        st_misalign,
  output logic [31:0] st_err_addr,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] ld_addr,
  output logic        ld_conflict,
  output logic        buf_empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_BAD  = 2'b11
  } size_e;

  // Buffer storage
  logic [29:0]      addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [3:0]       strb_q [DEPTH];
  logic [DEPTH-1:0] occ_q;

  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q,  count_d;
  logic          st_ready_q, buf_empty_q;
  logic          misalign_q;
  logic [31:0]   err_addr_q;

  size_e       size;
  logic [31:0] lane_data;
  logic [3:0]  lane_strb;
  logic        req_bad;
  logic        accept, push, pop;
  logic        conflict;

  // The low address bits of the load do not select a word.
  logic        ld_lo_unused;
  assign ld_lo_unused = ^ld_addr[1:0];

  assign size = size_e'(st_size);

  // Lane replication, strobes and alignment check
  always_comb begin
    lane_data = '0;
    lane_strb = '0;
    req_bad   = 1'b1;
    unique case (size)
      SZ_BYTE: begin
        lane_data = {4{st_wdata[7:0]}};
        lane_strb = 4'b0001 << st_addr[1:0];
        req_bad   = 1'b0;
      end
      SZ_HALF: begin
        lane_data = {2{st_wdata[15:0]}};
        lane_strb = st_addr[1] ? 4'b1100 : 4'b0011;
        req_bad   = st_addr[0];
      end
      SZ_WORD: begin
        lane_data = st_wdata;
        lane_strb = 4'b1111;
        req_bad   = |st_addr[1:0];
      end
      SZ_BAD: begin
        req_bad   = 1'b1;
      end
      default: begin
        req_bad   = 1'b1;
      end
    endcase
  end

  assign accept = st_valid && st_ready_q;
  assign push   = accept && !req_bad;
  assign pop    = mem_valid && mem_ready;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Occupancy bits let the conflict check look at every slot directly
  // instead of deriving the live range from the pointers and count.
  always_comb begin
    conflict = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (occ_q[i] && (addr_q[i] == ld_addr[31:2])) begin
        conflict = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        strb_q[i] <= '0;
      end
      occ_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      st_ready_q  <= 1'b1;
      buf_empty_q <= 1'b1;
      misalign_q  <= 1'b0;
      err_addr_q  <= '0;
    end else begin
      // Pop is applied before push. The two never target the same slot in
      // one cycle because push needs "not full" and pop needs "not empty".
      if (pop) begin
        occ_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q        <= rd_ptr_q + PW'(1);
      end
      if (push) begin
        addr_q[wr_ptr_q] <= st_addr[31:2];
        data_q[wr_ptr_q] <= lane_data;
        strb_q[wr_ptr_q] <= lane_strb;
        occ_q[wr_ptr_q]  <= 1'b1;
        wr_ptr_q         <= wr_ptr_q + PW'(1);
      end
      count_q     <= count_d;
      // st_ready and buf_empty depend only on the next count, so neither
      // has a combinational path from st_valid or mem_ready.
      st_ready_q  <= (count_d != CW'(DEPTH));
      buf_empty_q <= (count_d == '0);
      misalign_q  <= accept && req_bad;
      if (accept && req_bad) begin
        err_addr_q <= st_addr;
      end
    end
  end

  assign st_ready    = st_ready_q;
  assign buf_empty   = buf_empty_q;
  assign st_misalign = misalign_q;
  assign st_err_addr = err_addr_q;
  assign mem_valid   = (count_q != '0);
  assign mem_addr    = {addr_q[rd_ptr_q], 2'b00};
  assign mem_wdata   = data_q[rd_ptr_q];
  assign mem_wstrb   = strb_q[rd_ptr_q];
  assign ld_conflict = conflict;

endmodule

// File: tb/tb_dmem_store_align.sv
module tb_dmem_store_align;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_wdata;
  logic [1:0]  st_size;
  logic        st_misalign;
  logic [31:0] st_err_addr;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] ld_addr;
  logic        ld_conflict;
  logic        buf_empty;

  dmem_store_align #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .st_valid    (st_valid),
    .st_ready    (st_ready),
    .st_addr     (st_addr),
    .st_wdata    (st_wdata),
    .st_size     (st_size),
    .st_misalign (st_misalign),
    .st_err_addr (st_err_addr),
    .mem_valid   (mem_valid),
    .mem_ready   (mem_ready),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wstrb   (mem_wstrb),
    .ld_addr     (ld_addr),
    .ld_conflict (ld_conflict),
    .buf_empty   (buf_empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } exp_t;

  exp_t        sb[$];
  int          n_chk  = 0;
  int          n_pass = 0;
  bit          enable = 0;
  bit          mis_exp = 0;
  logic [31:0] err_exp = '0;

  bit          pend_acc, pend_bad;
  exp_t        pend_e;
  logic [31:0] pend_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference: n-byte access at byte offset off. Lane k carries byte (k mod n)
  // of the value; strobes cover bytes off..off+n-1.
  function automatic void ref_model(input logic [31:0] a, input logic [31:0] d,
                                    input logic [1:0] s, output bit bad, output exp_t e);
    int n;
    int off;
    n   = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    off = int'(a % 4);
    bad = (s == 2'd3) || ((off % n) != 0);
    e.addr = a & ~32'h3;
    for (int k = 0; k < 4; k++) begin
      e.data[8*k +: 8] = d[8*(k % n) +: 8];
      e.strb[k]        = (k >= off) && (k < off + n);
    end
  endfunction

  // Observe the request handshake mid-cycle; it takes effect at the next edge.
  always @(negedge clk) begin
    pend_acc  = rst_n && st_valid && st_ready;
    pend_addr = st_addr;
    ref_model(st_addr, st_wdata, st_size, pend_bad, pend_e);
  end

  // Stimulus side of the scoreboard: expected entries and error reports.
  always @(posedge clk) begin
    if (!rst_n) begin
      sb.delete();
      mis_exp = 0;
      err_exp = '0;
    end else begin
      mis_exp = pend_acc && pend_bad;
      if (pend_acc && pend_bad) err_exp = pend_addr;
      if (pend_acc && !pend_bad) sb.push_back(pend_e);
    end
  end

  // Monitor: compares DUT outputs against the model every cycle and pops
  // the head when the write-port handshake happens.
  always @(negedge clk) begin
    if (enable) begin
      bit hit;
      hit = 0;
      foreach (sb[i]) if (sb[i].addr[31:2] == ld_addr[31:2]) hit = 1;
      chk("mem_valid", {31'd0, mem_valid}, {31'd0, sb.size() != 0});
      chk("buf_empty", {31'd0, buf_empty}, {31'd0, sb.size() == 0});
      chk("st_ready", {31'd0, st_ready}, {31'd0, sb.size() < DEPTH});
      chk("ld_conflict", {31'd0, ld_conflict}, {31'd0, hit});
      chk("st_misalign", {31'd0, st_misalign}, {31'd0, mis_exp});
      chk("st_err_addr", st_err_addr, err_exp);
      if (mem_valid && sb.size() != 0) begin
        chk("mem_addr", mem_addr, sb[0].addr);
        chk("mem_wdata", mem_wdata, sb[0].data);
        chk("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, sb[0].strb});
        if (mem_ready && rst_n) void'(sb.pop_front());
      end
    end
  end

  // Caller is just after a rising edge; returns just after the accepting edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    bit ok;
    ok = 0;
    st_valid = 1'b1;
    st_addr  = a;
    st_wdata = d;
    st_size  = s;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (st_ready === 1'b1) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_chk++;
      $display("FAIL issue_timeout: st_ready stayed %b, expected 1 for addr %h", st_ready, a);
    end
    @(posedge clk); #1;
    st_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    mem_ready = 1'b1;
    for (int n = 0; n < 200; n++) begin
      step();
      if (sb.size() == 0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_chk++;
      $display("FAIL drain_timeout: %0d entries left, expected 0", sb.size());
    end
    step();
    mem_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    st_valid  = 1'b0;
    st_addr   = '0;
    st_wdata  = '0;
    st_size   = '0;
    mem_ready = 1'b0;
    ld_addr   = 32'hFFFF_FFF0;
    step(); step();
    @(negedge clk);
    chk("rst_st_ready", {31'd0, st_ready}, 32'd1);
    chk("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    chk("rst_buf_empty", {31'd0, buf_empty}, 32'd1);
    chk("rst_misalign", {31'd0, st_misalign}, 32'd0);
    chk("rst_err_addr", st_err_addr, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
    step();
    rst_n  = 1'b1;
    enable = 1;

    // Byte store, one-cycle latency into an empty buffer
    issue(32'h1003, 32'h0000_00AB, 2'b00);
    @(negedge clk);
    chk("byte_valid", {31'd0, mem_valid}, 32'd1);
    chk("byte_addr", mem_addr, 32'h1000);
    chk("byte_data", mem_wdata, 32'hABAB_ABAB);
    chk("byte_strb", {28'd0, mem_wstrb}, 32'b1000);
    drain();

    // Half stores: aligned upper half, then misaligned
    issue(32'h2002, 32'h0000_BEEF, 2'b01);
    @(negedge clk);
    chk("half_data", mem_wdata, 32'hBEEF_BEEF);
    chk("half_strb", {28'd0, mem_wstrb}, 32'b1100);
    drain();
    issue(32'h2001, 32'h0000_1234, 2'b01);
    @(negedge clk);
    chk("mis_pulse", {31'd0, st_misalign}, 32'd1);
    chk("mis_addr", st_err_addr, 32'h2001);
    chk("mis_empty", {31'd0, buf_empty}, 32'd1);
    step(); step();

    // Fill to full, then one pop
    for (int i = 0; i < 4; i++) issue(32'h10 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), 2'b10);
    @(negedge clk);
    chk("full_ready", {31'd0, st_ready}, 32'd0);
    step();
    mem_ready = 1'b1;
    @(negedge clk);
    chk("full_ready_pop", {31'd0, st_ready}, 32'd0);
    step();
    mem_ready = 1'b0;
    @(negedge clk);
    chk("after_pop_ready", {31'd0, st_ready}, 32'd1);
    chk("after_pop_head", mem_addr, 32'h14);
    drain();

    // Steady push+pop at count 2; pointers wrap several times
    issue(32'h100, 32'h1111_1111, 2'b10);
    issue(32'h104, 32'h2222_2222, 2'b10);
    mem_ready = 1'b1;
    for (int i = 0; i < 10; i++) issue(32'h200 + 32'(4 * i), $urandom, 2'b10);
    @(negedge clk);
    chk("pp_valid", {31'd0, mem_valid}, 32'd1);
    drain();

    // Load conflict
    issue(32'h40, 32'h5A5A_5A5A, 2'b10);
    ld_addr = 32'h43;
    @(negedge clk);
    chk("ldc_hit", {31'd0, ld_conflict}, 32'd1);
    step();
    ld_addr = 32'h44;
    @(negedge clk);
    chk("ldc_miss", {31'd0, ld_conflict}, 32'd0);
    step();
    ld_addr = 32'h40;
    drain();
    @(negedge clk);
    chk("ldc_drained", {31'd0, ld_conflict}, 32'd0);
    step();

    // Reset with entries pending
    for (int i = 0; i < 3; i++) issue(32'h300 + 32'(4 * i), 32'hDEAD_0000 + 32'(i), 2'b10);
    rst_n = 1'b0;
    step();
    @(negedge clk);
    chk("mrst_valid", {31'd0, mem_valid}, 32'd0);
    chk("mrst_empty", {31'd0, buf_empty}, 32'd1);
    chk("mrst_ready", {31'd0, st_ready}, 32'd1);
    step();
    rst_n = 1'b1;
    issue(32'h80, 32'h8080_8080, 2'b10);
    @(negedge clk);
    chk("mrst_first", mem_addr, 32'h80);
    drain();

    // Randomized traffic over a small address window
    for (int c = 0; c < 400; c++) begin
      step();
      st_valid  = ($urandom_range(0, 9) < 7);
      st_addr   = 32'h100 + 32'($urandom_range(0, 31));
      st_wdata  = $urandom;
      st_size   = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      mem_ready = ($urandom_range(0, 2) != 0);
      ld_addr   = 32'h100 + 32'($urandom_range(0, 31));
    end
    step();
    st_valid = 1'b0;
    drain();
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
